// File: rtl/lcd_menu_writer.sv
// lcd_menu_writer: button-stepped menu that redraws an LCD from a text ROM over Avalon-MM
module lcd_menu_writer #(
  parameter int N_ENTRIES = 4,
  parameter int N_CHARS = 16,
  parameter int WRAP = 1,
  parameter int CHOICE_W = $clog2(N_ENTRIES),
  parameter int ROM_AW = $clog2(N_ENTRIES * N_CHARS)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_left,
  input  logic btn_right,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic address,
  output logic chipselect,
  output logic byteenable,
  output logic read,
  output logic write,
  output logic [7:0] writedata,
  input  logic waitrequest,
  output logic [CHOICE_W-1:0] menu_choice,
  output logic busy
);
  localparam int IDX_W = N_CHARS > 1 ? $clog2(N_CHARS) : 1;
  localparam logic [CHOICE_W-1:0] LAST = CHOICE_W'(N_ENTRIES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHARS - 1);
  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, ROM_WAIT, WRITE_CHAR} state_t;
  state_t state_q, state_d;
  logic pending_q, pending_d, done;
  logic [CHOICE_W-1:0] choice_q, choice_d, draw_q, draw_d, inc, dec;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  assign write = state_q == CLEAR || state_q == WRITE_CHAR;
  assign chipselect = write;
  assign address = state_q == WRITE_CHAR;
  assign writedata = state_q == CLEAR ? 8'h01 : address ? data_q : 8'h00;
  assign byteenable = 1'b1;
  assign read = 1'b0;
  assign menu_choice = choice_q;
  assign busy = state_q != IDLE || pending_q;
  assign rom_addr = ROM_AW'(draw_q) * ROM_AW'(N_CHARS) + ROM_AW'(idx_q);
  assign done = write && !waitrequest;
  always_comb begin
    inc = choice_q == LAST ? (WRAP != 0 ? '0 : LAST) : choice_q + 1'b1;
    dec = choice_q == '0 ? (WRAP != 0 ? LAST : '0) : choice_q - 1'b1;
    choice_d = btn_right && !btn_left ? inc : btn_left && !btn_right ? dec : choice_q;
    pending_d = choice_d != choice_q || (pending_q && state_q != IDLE);
    data_d = state_q == ROM_WAIT ? rom_data : data_q;
    state_d = state_q;
    draw_d = draw_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: if (pending_q) begin
        state_d = CLEAR;
        draw_d = choice_q;
        idx_d = '0;
      end
      CLEAR: if (done) state_d = pending_q ? IDLE : FETCH;
      FETCH: state_d = pending_q ? IDLE : ROM_WAIT;
      ROM_WAIT: state_d = pending_q ? IDLE : WRITE_CHAR;
      WRITE_CHAR: if (done) begin
        state_d = pending_q || idx_q == LAST_IDX ? IDLE : FETCH;
        idx_d = idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pending_q <= 1'b1;
      choice_q <= '0;
      draw_q <= '0;
      idx_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      choice_q <= choice_d;
      draw_q <= draw_d;
      idx_q <= idx_d;
      data_q <= data_d;
    end
  end
endmodule

// File: tb/tb_lcd_menu_writer.sv
// tb_lcd_menu_writer: three lcd_menu_writer configurations checked against a behavioural model
module tb_lcd_menu_writer;
  localparam int NI = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic bl[NI], br[NI], wq[NI], wr[NI], ad[NI], cs[NI], be[NI], rd_o[NI], bsy[NI];
  logic [7:0] wd[NI], ra[NI], rdat[NI];
  logic [3:0] mc[NI];
  int tests = 0;
  int fails = 0;
  int m_ch[NI], draw[NI], k[NI], nx[NI], bc[NI];
  bit dirty[NI], extra[NI], hold[NI], started[NI];
  logic pad[NI];
  logic [7:0] pwd[NI], first_d[NI], last_d[NI];
  function automatic int ne_of(int i);
    return i == 2 ? 6 : 4;
  endfunction
  function automatic int nc_of(int i);
    return i == 2 ? 8 : 16;
  endfunction
  function automatic bit wrap_of(int i);
    return i != 1;
  endfunction
  function automatic logic [7:0] rom_val(int a);
    string s = "Option 1        ";
    return a < 16 ? s[a] : 8'(8'h80 + a);
  endfunction
  function automatic int next_choice(int i, int m, logic l, logic r);
    int n = ne_of(i);
    if (r && !l) return wrap_of(i) ? (m + 1) % n : (m + 1 < n ? m + 1 : n - 1);
    if (l && !r) return wrap_of(i) ? (m + n - 1) % n : (m > 0 ? m - 1 : 0);
    return m;
  endfunction
  for (genvar g = 0; g < NI; g++) begin : cfg
    localparam int NE = g == 2 ? 6 : 4;
    localparam int NC = g == 2 ? 8 : 16;
    localparam int WR = g == 1 ? 0 : 1;
    logic [$clog2(NE*NC)-1:0] ra_l;
    logic [$clog2(NE)-1:0] mc_l;
    lcd_menu_writer #(.N_ENTRIES(NE), .N_CHARS(NC), .WRAP(WR)) dut (
      .clk(clk), .reset(rst), .btn_left(bl[g]), .btn_right(br[g]),
      .rom_addr(ra_l), .rom_data(rdat[g]), .address(ad[g]), .chipselect(cs[g]),
      .byteenable(be[g]), .read(rd_o[g]), .write(wr[g]), .writedata(wd[g]),
      .waitrequest(wq[g]), .menu_choice(mc_l), .busy(bsy[g]));
    assign ra[g] = 8'(ra_l);
    assign mc[g] = 4'(mc_l);
  end
  always @(posedge clk) for (int i = 0; i < NI; i++) rdat[i] <= rom_val(int'(ra[i]));
  task automatic chk(string name, int i, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cfg%0d: got %0d expected %0d", name, i, act, exp);
    end
  endtask
  task automatic mreset();
    for (int i = 0; i < NI; i++) begin
      m_ch[i] = 0; draw[i] = 0; k[i] = 0; nx[i] = 0; bc[i] = 0;
      dirty[i] = 0; extra[i] = 0; hold[i] = 0; started[i] = 0;
    end
  endtask
  task automatic monitor();
    if (rst) begin
      mreset();
      return;
    end
    for (int i = 0; i < NI; i++) begin
      int n;
      chk("menu_choice", i, mc[i], m_ch[i]);
      chk("chipselect", i, cs[i], wr[i]);
      chk("byteenable", i, be[i], 1);
      chk("read", i, rd_o[i], 0);
      if (!wr[i]) chk("idle_writedata", i, wd[i], 0);
      if (hold[i]) begin
        chk("held_write", i, wr[i], 1);
        chk("held_address", i, ad[i], pad[i]);
        chk("held_writedata", i, wd[i], pwd[i]);
      end
      if (bsy[i]) bc[i]++;
      if (wr[i] && !wq[i]) begin
        nx[i]++;
        if (!ad[i]) begin
          chk("clear_data", i, wd[i], 1);
          draw[i] = m_ch[i]; k[i] = 0; dirty[i] = 0; extra[i] = 0; started[i] = 1;
        end else begin
          chk("char_in_range", i, started[i] && k[i] < nc_of(i), 1);
          chk("char_data", i, wd[i], rom_val(draw[i] * nc_of(i) + k[i]));
          if (k[i] == 0) first_d[i] = wd[i];
          last_d[i] = wd[i];
          if (dirty[i]) begin
            chk("abort_extra_char", i, extra[i], 0);
            extra[i] = 1;
          end
          k[i]++;
        end
      end
      hold[i] = wr[i] && wq[i];
      pad[i] = ad[i];
      pwd[i] = wd[i];
      n = next_choice(i, m_ch[i], bl[i], br[i]);
      if (n != m_ch[i]) dirty[i] = 1;
      m_ch[i] = n;
    end
  endtask
  task automatic rst_chk();
    for (int i = 0; i < NI; i++) begin
      chk("rst_choice", i, mc[i], 0);
      chk("rst_write", i, wr[i], 0);
      chk("rst_address", i, ad[i], 0);
      chk("rst_writedata", i, wd[i], 0);
      chk("rst_rom_addr", i, ra[i], 0);
      chk("rst_busy", i, bsy[i], 1);
    end
  endtask
  task automatic settle();
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while ((bsy[0] || bsy[1] || bsy[2]) && c < 3000);
    @(posedge clk);
    #1;
    chk("settle_in_time", 0, c < 3000, 1);
    for (int i = 0; i < NI; i++) begin
      chk("final_length", i, k[i], nc_of(i));
      chk("final_entry", i, draw[i], m_ch[i]);
      chk("final_idle", i, bsy[i], 0);
    end
  endtask
  task automatic pulse(logic [2:0] l, logic [2:0] r);
    for (int i = 0; i < NI; i++) begin
      bl[i] = l[i];
      br[i] = r[i];
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      bl[i] = 1'b0;
      br[i] = 1'b0;
    end
  endtask
  initial begin
    int s[NI];
    int c, st;
    int exp_r[5][3] = '{'{0, 1, 0}, '{1, 2, 1}, '{2, 3, 2}, '{3, 3, 3}, '{0, 3, 4}};
    int exp_dx[5][3] = '{'{17, 17, 9}, '{17, 17, 9}, '{17, 17, 9}, '{17, 0, 9}, '{17, 0, 9}};
    for (int i = 0; i < NI; i++) begin
      bl[i] = 1'b0; br[i] = 1'b0; wq[i] = 1'b0;
    end
    fork
      forever begin
        @(negedge clk);
        monitor();
      end
      begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    rst_chk();
    rst = 1'b0;
    c = 0;
    while (k[0] != 2 && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("reach_third_char", 0, k[0], 2);
    wq[0] = 1'b1;
    c = 0;
    st = 0;
    while (st < 5 && c < 50) begin
      @(negedge clk);
      c++;
      if (wr[0]) st++;
    end
    @(posedge clk);
    #1;
    wq[0] = 1'b0;
    chk("stall_cycles", 0, st, 5);
    settle();
    chk("busy_cycles", 0, bc[0], 55);
    chk("busy_cycles", 1, bc[1], 50);
    chk("busy_cycles", 2, bc[2], 26);
    chk("transfers", 0, nx[0], 17);
    chk("transfers", 1, nx[1], 17);
    chk("transfers", 2, nx[2], 9);
    chk("first_char", 0, first_d[0], 8'h4F);
    chk("last_char", 0, last_d[0], 8'h20);
    for (int i = 0; i < NI; i++) s[i] = nx[i];
    pulse(3'b111, 3'b000);
    settle();
    chk("left_choice", 0, mc[0], 3);
    chk("left_choice", 1, mc[1], 0);
    chk("left_choice", 2, mc[2], 5);
    chk("left_transfers", 0, nx[0] - s[0], 17);
    chk("left_transfers", 1, nx[1] - s[1], 0);
    chk("left_transfers", 2, nx[2] - s[2], 9);
    chk("entry5_first", 2, first_d[2], 8'hA8);
    chk("entry5_last", 2, last_d[2], 8'hAF);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < NI; i++) s[i] = nx[i];
      pulse(3'b000, 3'b111);
      settle();
      for (int i = 0; i < NI; i++) begin
        chk("right_choice", i, mc[i], exp_r[r][i]);
        chk("right_transfers", i, nx[i] - s[i], exp_dx[r][i]);
      end
    end
    for (int i = 0; i < NI; i++) s[i] = nx[i];
    pulse(3'b111, 3'b111);
    settle();
    for (int i = 0; i < NI; i++) begin
      chk("both_choice", i, mc[i], exp_r[4][i]);
      chk("both_transfers", i, nx[i] - s[i], 0);
    end
    s[0] = nx[0];
    pulse(3'b000, 3'b001);
    c = 0;
    while (k[0] != 6 && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("reach_seventh_char", 0, k[0], 6);
    wq[0] = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!wr[0] && c < 20);
    @(posedge clk);
    #1;
    pulse(3'b000, 3'b001);
    wq[0] = 1'b0;
    settle();
    chk("abort_choice", 0, mc[0], 2);
    chk("abort_transfers", 0, nx[0] - s[0], 25);
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NI; i++) begin
        bl[i] = $urandom_range(0, 19) == 0;
        br[i] = $urandom_range(0, 19) == 0;
        wq[i] = $urandom_range(0, 2) == 0;
      end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < NI; i++) begin
      bl[i] = 1'b0; br[i] = 1'b0; wq[i] = 1'b0;
    end
    settle();
    for (int i = 0; i < NI; i++) wq[i] = 1'b1;
    pulse(3'b000, 3'b111);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst_chk();
    rst = 1'b0;
    for (int i = 0; i < NI; i++) wq[i] = 1'b0;
    settle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lcd_menu_writer.md
Name: lcd_menu_writer

Overview:
- Parametrised successor to the fixed 4-entry LCD menu writer.
- Holds a menu selection of N_ENTRIES items, stepped by left/right button pulses. On every selection change it redraws the LCD: CLEAR_DISPLAY, then N_CHARS characters read from an external text ROM.
- Acts as an Avalon-MM master to the LCD_Controller slave. Publishes the current choice to downstream image-mode logic.
- New over the previous block: arbitrary entry count, ROM-backed text, selectable wrap/saturate, and a clean abort/restart when a button is pressed mid-redraw.

Parameters:
- N_ENTRIES, 4, number of menu entries (≥2).
- N_CHARS, 16, characters written per entry after the clear (1..32).
- WRAP, 1, 1 = selection wraps at the ends; 0 = selection saturates at 0 and N_ENTRIES-1.
- CHOICE_W, $clog2(N_ENTRIES), width of menu_choice.
- ROM_AW, $clog2(N_ENTRIES*N_CHARS), text ROM address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- btn_left  in  1  single-cycle pulse, already edge-detected upstream: previous entry.
- btn_right  in  1  single-cycle pulse, already edge-detected upstream: next entry.
- rom_addr  out  ROM_AW  text ROM address = menu_choice*N_CHARS + char_idx.
- rom_data  in  8  ROM character; valid the cycle after rom_addr is presented.
- address  out  1  Avalon address: 0 = instruction, 1 = data.
- chipselect  out  1  equals write.
- byteenable  out  1  constant 1.
- read  out  1  constant 0.
- write  out  1  Avalon write strobe.
- writedata  out  8  Avalon write data; 0 when write=0.
- waitrequest  in  1  Avalon slave stall.
- menu_choice  out  CHOICE_W  current selection.
- busy  out  1  high while a redraw is in progress or pending.

Behaviour:
- Reset values: menu_choice=0, write=0, address=0, writedata=0, rom_addr=0, state=IDLE, pending=1. The first redraw starts right after reset.
- Selection update, on the cycle a pulse is seen:
  - Right only: WRAP=1 gives (choice+1) mod N_ENTRIES; WRAP=0 gives min(choice+1, N_ENTRIES-1).
  - Left only: WRAP=1 gives (choice-1) mod N_ENTRIES (0 goes to N_ENTRIES-1); WRAP=0 gives max(choice-1, 0).
  - Both pulses in the same cycle: ignored. No choice change, no redraw.
  - A pulse that leaves the choice unchanged (saturated case) does not set pending.
  - Any pulse that changes the choice sets pending=1.
- Avalon transaction rule: write, address and writedata are held stable from assertion until the cycle where write=1 and waitrequest=0. That cycle completes the transfer, and write drops the next cycle. At most one transfer is outstanding.
- FSM states:
  - IDLE: if pending, clear pending, latch choice into draw_choice, set char_idx=0, go to CLEAR.
  - CLEAR: write=1, address=0, writedata=8'h01. When the transfer completes, go to FETCH.
  - FETCH: drive rom_addr = draw_choice*N_CHARS + char_idx, go to ROM_WAIT.
  - ROM_WAIT: capture rom_data into a data register, go to WRITE_CHAR.
  - WRITE_CHAR: write=1, address=1, writedata = captured char. On completion:
    - if char_idx = N_CHARS-1, go to IDLE;
    - otherwise char_idx+1, go to FETCH.
- Abort:
  - If pending becomes 1 while in CLEAR/FETCH/ROM_WAIT/WRITE_CHAR, the in-flight Avalon transfer (if any) still completes normally. Never deassert write while waitrequest=1.
  - After that completion, or immediately if in FETCH/ROM_WAIT, go to IDLE, which restarts the redraw with the new choice.
- Redraw length with waitrequest tied 0: 1 clear transfer + N_CHARS × 3 cycles (FETCH, ROM_WAIT, WRITE_CHAR). N_CHARS=16 gives 1+48 = 49 cycles in non-IDLE states.
- busy = (state≠IDLE) | pending.
- menu_choice updates immediately on a pulse, independent of redraw progress.
- reset asserted mid-transfer: all outputs go to reset values the next cycle, regardless of waitrequest. This is the one exception to the hold rule; the LCD controller is reset from the same source.
- rom_addr arithmetic is done at ROM_AW bits and never overflows by construction.

Test Plan:
- Reset release, waitrequest=0, ROM entry 0 = "Option 1        " → write 8'h01 at address 0, then 16 data writes at address 1 matching ROM[0..15]; busy drops after 49 cycles; menu_choice=0.
- Hold waitrequest=1 for 5 cycles during the 3rd character → write, address and writedata stable all 5 cycles; exactly one transfer is counted; sequence continues with the 4th character.
- WRAP=1, N_ENTRIES=4: right ×5 → menu_choice 1,2,3,0,1. Left from 0 → 3. Each change triggers a redraw reading rom_addr base choice*16.
- WRAP=0: left at 0 → menu_choice stays 0, no redraw. Right at 3 → stays 3, no redraw.
- Right pulse during the 7th character with waitrequest=1 → that write completes, no further characters for the old entry, new clear+16 chars for entry+1. Both pulses together → nothing happens.
- N_ENTRIES=6, N_CHARS=8: step to entry 5 → rom_addr 40..47; total 9 Avalon writes.
